// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants, instruction field slices and fetch FSM states
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [5:0]  OP_B      = 6'b000101;

  // BrAddr26 lives in [25:0], CondAddr19 in [23:5]
  localparam int BR26_HI   = 25;
  localparam int BR26_LO   = 0;
  localparam int COND19_HI = 23;
  localparam int COND19_LO = 5;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/branch_target.sv
// rtl/branch_target.sv - combinational branch target adder for the ID instruction
// Purpose: target = id_pc + (sext(off) << 2), where off is BrAddr26 or CondAddr19.
// Ports:
//   id_pc    in  PC_W : PC of the instruction in IF/ID
//   id_instr in  32   : instruction in IF/ID
//   UncondBr in  1    : 1 selects the 26-bit offset, 0 the 19-bit offset
//   target   out PC_W : branch target, wraps modulo 2^PC_W
module branch_target
  import cpu_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  logic [PC_W-1:0] id_pc,
  input  logic [31:0]     id_instr,
  input  logic            UncondBr,
  output logic [PC_W-1:0] target
);

  localparam int W26 = BR26_HI - BR26_LO + 1;
  localparam int W19 = COND19_HI - COND19_LO + 1;

  logic [W26-1:0]  off26;
  logic [W19-1:0]  off19;
  logic [PC_W-1:0] off_ext;
  logic            unused_opcode;

  assign off26 = id_instr[BR26_HI:BR26_LO];
  assign off19 = id_instr[COND19_HI:COND19_LO];

  // The opcode field plays no part in the target computation.
  assign unused_opcode = ^id_instr[31:26];

  always_comb begin
    off_ext = '0;
    if (UncondBr) begin
      off_ext = {{(PC_W-W26){off26[W26-1]}}, off26};
    end else begin
      off_ext = {{(PC_W-W19){off19[W19-1]}}, off19};
    end
  end

  assign target = id_pc + (off_ext << 2);

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - LEGv8 instruction fetch stage with PC, IF/ID register and halt FSM
// Purpose: owns the PC, drives instruction memory and registers fetched words into IF/ID.
//   One branch delay slot: a taken branch in ID redirects the PC at the same edge
//   that captures the following instruction.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   imem_addr    : out, byte address to instruction memory (= pc)
//   imem_rdata   : in, instruction word at imem_addr, same cycle
//   stall        : in, freezes PC and IF/ID
//   Brtaken      : in, take-branch decision for the ID instruction
//   UncondBr     : in, offset select for the target (26-bit when 1)
//   id_instr, id_pc, id_valid : out, IF/ID register
//   halted       : out, branch-to-self reached
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            Brtaken,
  input  logic            UncondBr,
  output logic [31:0]     id_instr,
  output logic [PC_W-1:0] id_pc,
  output logic            id_valid,
  output logic            halted
);

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [31:0]     id_instr_nxt;
  logic [PC_W-1:0] id_pc_nxt;
  logic            id_valid_nxt;
  logic [PC_W-1:0] target;
  logic            redirect;
  logic            halt_hit;

  branch_target #(.PC_W(PC_W)) u_branch_target (
    .id_pc    (id_pc),
    .id_instr (id_instr),
    .UncondBr (UncondBr),
    .target   (target)
  );

  // Masking with id_valid keeps an undriven Brtaken behind a bubble out of the PC.
  assign redirect = Brtaken & id_valid;
  assign halt_hit = redirect && (id_instr[31:26] == OP_B)
                    && (id_instr[BR26_HI:BR26_LO] == '0);

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    id_instr_nxt = id_instr;
    id_pc_nxt    = id_pc;
    id_valid_nxt = id_valid;
    case (state)
      BOOT: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (!stall) begin
          // Delay slot is always captured, taken branch or not.
          id_instr_nxt = imem_rdata;
          id_pc_nxt    = pc;
          id_valid_nxt = 1'b1;
          if (halt_hit) begin
            pc_nxt    = id_pc;
            state_nxt = HALT;
          end else if (redirect) begin
            pc_nxt = target;
          end else begin
            pc_nxt = pc + PC_W'(4);
          end
        end
      end
      HALT: begin
        id_instr_nxt = NOP_INSTR;
        id_valid_nxt = 1'b0;
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
      id_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      id_instr <= id_instr_nxt;
      id_pc    <= id_pc_nxt;
      id_valid <= id_valid_nxt;
    end
  end

  assign imem_addr = pc;
  assign halted    = (state == HALT);

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        Brtaken;
  logic        UncondBr;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic        id_valid;
  logic        halted;

  logic [31:0] mem [0:63];

  int checks;
  int errors;

  if_fetch_stage #(.PC_W(64), .RESET_PC(64'h0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .Brtaken    (Brtaken),
    .UncondBr   (UncondBr),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_valid   (id_valid),
    .halted     (halted)
  );

  assign imem_rdata = mem[imem_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset_n  = 1'b0;
    stall    = 1'b0;
    Brtaken  = 1'b0;
    UncondBr = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i * 4);
    mem[0]  = 32'h9100_0421;   // addr 0
    mem[2]  = 32'h1400_0003;   // addr 8:  B +3 words -> 20
    mem[4]  = 32'h1400_0000;   // addr 16: B to self
    mem[10] = 32'h54FF_FFC0;   // addr 40: B.cond imm19 = -2 -> 32

    #12;
    check("rst_addr", imem_addr, 64'h0);
    check("rst_valid", {63'b0, id_valid}, 64'h0);
    check("rst_instr", {32'b0, id_instr}, 64'h0);
    check("rst_halted", {63'b0, halted}, 64'h0);

    // Boot; Brtaken held high must be masked while IF/ID is empty.
    Brtaken  = 1'b1;
    UncondBr = 1'b1;
    do_reset();
    step();
    check("boot_valid", {63'b0, id_valid}, 64'h0);
    check("boot_addr", imem_addr, 64'h0);
    step();
    check("first_instr", {32'b0, id_instr}, 64'h9100_0421);
    check("first_pc", id_pc, 64'h0);
    check("first_valid", {63'b0, id_valid}, 64'h1);
    check("first_addr", imem_addr, 64'h4);
    Brtaken = 1'b0;
    step();
    step();
    check("b_in_id", {32'b0, id_instr}, 64'h1400_0003);

    // Unconditional branch at 8 -> 20, delay slot 12
    Brtaken  = 1'b1;
    UncondBr = 1'b1;
    step();
    Brtaken  = 1'b0;
    check("ub_addr", imem_addr, 64'd20);
    check("ub_slot_pc", id_pc, 64'd12);
    check("ub_slot_instr", {32'b0, id_instr}, 64'hA000_000C);
    step();
    check("ub_target_pc", id_pc, 64'd20);
    for (int i = 0; i < 5; i++) step();
    check("bc_in_id_pc", id_pc, 64'd40);
    check("bc_in_id", {32'b0, id_instr}, 64'h54FF_FFC0);

    // Backward conditional branch at 40 -> 32, delay slot 44
    Brtaken  = 1'b1;
    UncondBr = 1'b0;
    step();
    Brtaken  = 1'b0;
    check("bc_addr", imem_addr, 64'd32);
    check("bc_slot_pc", id_pc, 64'd44);
    check("bc_slot_instr", {32'b0, id_instr}, 64'hA000_002C);

    // Re-reach the B.cond at 40 and stall with it in ID
    step();
    step();
    step();
    check("st_pre_pc", id_pc, 64'd40);
    Brtaken = 1'b1;
    stall   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("st_hold_addr", imem_addr, 64'd44);
      check("st_hold_pc", id_pc, 64'd40);
      check("st_hold_instr", {32'b0, id_instr}, 64'h54FF_FFC0);
      check("st_hold_valid", {63'b0, id_valid}, 64'h1);
    end
    stall = 1'b0;
    step();
    Brtaken = 1'b0;
    check("st_redir_addr", imem_addr, 64'd32);
    check("st_redir_pc", id_pc, 64'd44);

    // Halt on B-to-self at 16
    do_reset();
    for (int i = 0; i < 6; i++) step();
    check("h_pre_pc", id_pc, 64'd16);
    check("h_pre_addr", imem_addr, 64'd20);
    check("h_pre_halted", {63'b0, halted}, 64'h0);
    Brtaken  = 1'b1;
    UncondBr = 1'b1;
    step();
    check("h_halted", {63'b0, halted}, 64'h1);
    check("h_addr", imem_addr, 64'd16);
    check("h_slot_pc", id_pc, 64'd20);
    check("h_slot_instr", {32'b0, id_instr}, 64'hA000_0014);
    check("h_slot_valid", {63'b0, id_valid}, 64'h1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("h_bubble_valid", {63'b0, id_valid}, 64'h0);
      check("h_bubble_instr", {32'b0, id_instr}, 64'h0);
      check("h_hold_addr", imem_addr, 64'd16);
      check("h_hold_halted", {63'b0, halted}, 64'h1);
    end

    // Asynchronous reset while halted
    #2 reset_n = 1'b0;
    #1;
    check("hr_halted", {63'b0, halted}, 64'h0);
    check("hr_addr", imem_addr, 64'h0);
    stall    = 1'b0;
    Brtaken  = 1'b0;
    UncondBr = 1'b0;

    // Asynchronous reset mid-run at pc = 0x24
    do_reset();
    for (int i = 0; i < 10; i++) step();
    check("ar_pre_addr", imem_addr, 64'h24);
    check("ar_pre_valid", {63'b0, id_valid}, 64'h1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_addr", imem_addr, 64'h0);
    check("ar_valid", {63'b0, id_valid}, 64'h0);
    check("ar_halted", {63'b0, halted}, 64'h0);
    check("ar_instr", {32'b0, id_instr}, 64'h0);
    check("ar_id_pc", id_pc, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
